// File: rtl/vreg_burst_arbiter.sv
// Burst scheduler for one vector register bank: round-robin lane arbitration,
// then per-beat address/strobe/last generation for the winner's whole burst.
module vreg_burst_arbiter #(
    parameter int unsigned NUM_PORT = 4,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned LEN_W    = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORT-1:0]         req_vld,
    input  logic [NUM_PORT*LEN_W-1:0]   req_len,
    input  logic [NUM_PORT*ADDR_W-1:0]  req_addr,
    input  logic [NUM_PORT-1:0]         req_write,
    input  logic                        stall,
    output logic [NUM_PORT-1:0]         grant,
    output logic [$clog2(NUM_PORT)-1:0] grant_id,
    output logic                        beat_vld,
    output logic [ADDR_W-1:0]           beat_addr,
    output logic                        beat_write,
    output logic                        beat_last,
    output logic [NUM_PORT-1:0]         done,
    output logic                        busy
);

    localparam int unsigned ID_W = $clog2(NUM_PORT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   start_q;
    logic                write_q;
    logic [LEN_W-1:0]    beat_cnt;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [LEN_W-1:0]    win_len;
    logic [ADDR_W-1:0]   win_addr;
    int unsigned         idx;
    logic [NUM_PORT-1:0] owner_oh;
    logic                at_last;

    // First requesting port at or after rr_ptr, searching upward with wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_PORT; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_PORT;
            if (!win_found && req_vld[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign win_len  = req_len[win_id*LEN_W +: LEN_W];
    assign win_addr = req_addr[win_id*ADDR_W +: ADDR_W];
    assign at_last  = (beat_cnt == len_q - LEN_W'(1));

    // Next-state and beat issue decode.
    always_comb begin
        state_nxt = state;
        beat_vld  = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found) state_nxt = S_BURST;
            end
            S_BURST: begin
                beat_vld = !stall;
                if (!stall && at_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign owner_oh   = NUM_PORT'(1) << id_q;
    assign busy       = (state != S_IDLE);
    assign grant      = busy ? owner_oh : '0;
    assign grant_id   = busy ? id_q : '0;
    assign done       = (state == S_DONE) ? owner_oh : '0;
    assign beat_addr  = start_q + ADDR_W'(beat_cnt);
    assign beat_write = beat_vld & write_q;
    assign beat_last  = beat_vld & at_last;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Burst context is latched on the grant edge; later request changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            start_q  <= '0;
            write_q  <= 1'b0;
            beat_cnt <= '0;
        end else if (state == S_IDLE && win_found) begin
            id_q     <= win_id;
            len_q    <= (win_len == '0) ? LEN_W'(1) : win_len;
            start_q  <= win_addr;
            write_q  <= req_write[win_id];
            beat_cnt <= '0;
            rr_ptr   <= (win_id == ID_W'(NUM_PORT - 1)) ? '0 : win_id + ID_W'(1);
        end else if (beat_vld) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

endmodule
